// File: rtl/i2c_pkg.sv
// Shared constants for the memory-mapped I2C master: FSM encoding, CMD/STATUS
// bit positions, register offsets and the helper that picks a command's first state.
package i2c_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_BIT   = 3'd2;
  localparam logic [2:0] ST_ACK   = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;

  localparam int CMD_START_BIT = 8;
  localparam int CMD_WRITE_BIT = 9;
  localparam int CMD_READ_BIT  = 10;
  localparam int CMD_STOP_BIT  = 11;
  localparam int CMD_NACK_BIT  = 12;

  localparam logic [1:0] REG_CMD    = 2'd0;
  localparam logic [1:0] REG_RXDATA = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_CLEAR  = 2'd3;

  localparam int STAT_BUSY     = 0;
  localparam int STAT_NACK     = 1;
  localparam int STAT_ERR      = 2;
  localparam int STAT_RX_VALID = 3;

  // Commands execute START -> byte -> STOP, skipping whichever parts are absent.
  function automatic logic [2:0] first_state(input logic start, input logic byte_op,
                                             input logic stop);
    if (start)   return ST_START;
    if (byte_op) return ST_BIT;
    if (stop)    return ST_STOP;
    return ST_IDLE;
  endfunction

endpackage

// File: rtl/i2c_phase_gen.sv
// Quarter-phase timing for the I2C master: DIV-cycle divider plus 2-bit quarter
// counter, idle at zero while not running, with a freeze input for clock stretching.
module i2c_phase_gen #(
  parameter int unsigned DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       freeze,
  output logic [1:0] quarter,
  output logic       q_strobe,
  output logic       state_end
);

  localparam int unsigned CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] div_cnt;

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // flop samples the pre-edge values of its neighbours regardless of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      quarter <= '0;
    end else if (!run) begin
      div_cnt <= '0;
      quarter <= '0;
    end else if (!freeze) begin
      if (div_cnt == LAST) begin
        div_cnt <= '0;
        quarter <= quarter + 2'd1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // The strobe may repeat while frozen in q1; the actions it triggers are idempotent.
  assign q_strobe  = run && (div_cnt == '0);
  assign state_end = run && !freeze && (quarter == 2'd3) && (div_cnt == LAST);

endmodule

// File: rtl/i2c_master.sv
// Memory-mapped byte-level I2C master (CMD/RXDATA/STATUS/CLEAR window).
// Define I2C_CLOCK_STRETCH_EN to let a slave hold SCL low and stall q1.
module i2c_master
  import i2c_pkg::*;
#(
  parameter int unsigned       DATA_W    = 16,
  parameter int unsigned       ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 'hF0,
  parameter int unsigned       DIV       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              we,
  output logic [DATA_W-1:0] rdata,
  output logic              hit,
  output logic              scl_oe,
  output logic              sda_oe,
  input  logic              scl_i,
  input  logic              sda_i
);

  logic [1:0]        scl_sync, sda_sync;
  logic              scl_s, sda_s;
  logic              busy, slave_nack, err, rx_valid;
  logic [7:0]        rx_data, shreg;
  logic [2:0]        state, bit_cnt;
  logic              cmd_byte, cmd_read, cmd_stop, cmd_nack;
  logic [1:0]        quarter;
  logic              q_strobe, state_end, stretch;
  logic [ADDR_W-1:0] offset;
  logic [1:0]        reg_sel;
  logic              cmd_we, clr_we, w_write, w_read, w_any, w_conflict, accept;
  logic              unused_bits;

  // NOTE: synchroniser flops reset to 1 (idle bus level) so no false edge is seen
  // after reset; only control/status flops get a reset, there is no memory here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
    end
  end
  assign scl_s = scl_sync[1];
  assign sda_s = sda_sync[1];

  assign offset  = addr - BASE_ADDR;
  assign hit     = (addr >= BASE_ADDR) && (offset[ADDR_W-1:2] == '0);
  assign reg_sel = offset[1:0];
  assign cmd_we  = we && hit && (reg_sel == REG_CMD);
  assign clr_we  = we && hit && (reg_sel == REG_CLEAR);

  assign w_write    = wdata[CMD_WRITE_BIT];
  assign w_read     = wdata[CMD_READ_BIT];
  assign w_any      = |wdata[CMD_STOP_BIT:CMD_START_BIT];
  assign w_conflict = w_write && w_read;
  assign accept     = cmd_we && !busy && !w_conflict && w_any;

`ifdef I2C_CLOCK_STRETCH_EN
  assign stretch = busy && (quarter == 2'd1) && !scl_s;
`else
  assign stretch = 1'b0;
`endif
  assign unused_bits = ^{wdata, scl_s};

  i2c_phase_gen #(.DIV(DIV)) u_phase (
    .clk       (clk),
    .rst       (rst),
    .run       (busy),
    .freeze    (stretch),
    .quarter   (quarter),
    .q_strobe  (q_strobe),
    .state_end (state_end)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy       <= 1'b0;
      slave_nack <= 1'b0;
      err        <= 1'b0;
      rx_valid   <= 1'b0;
      rx_data    <= '0;
      shreg      <= '0;
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      cmd_byte   <= 1'b0;
      cmd_read   <= 1'b0;
      cmd_stop   <= 1'b0;
      cmd_nack   <= 1'b0;
      scl_oe     <= 1'b0;
      sda_oe     <= 1'b0;
    end else begin
      if (clr_we) begin
        err      <= 1'b0;
        rx_valid <= 1'b0;
      end
      if (cmd_we && (busy || w_conflict)) err <= 1'b1;

      if (accept) begin
        busy     <= 1'b1;
        state    <= first_state(wdata[CMD_START_BIT], w_write || w_read, wdata[CMD_STOP_BIT]);
        cmd_byte <= w_write || w_read;
        cmd_read <= w_read;
        cmd_stop <= wdata[CMD_STOP_BIT];
        cmd_nack <= wdata[CMD_NACK_BIT];
        shreg    <= wdata[7:0];
        bit_cnt  <= '0;
      end else if (busy) begin
        if (q_strobe) begin
          case (state)
            ST_START: case (quarter)
              2'd0:    sda_oe <= 1'b0;
              2'd1:    scl_oe <= 1'b0;
              2'd2:    sda_oe <= 1'b1;
              default: scl_oe <= 1'b1;
            endcase
            ST_BIT: case (quarter)
              2'd0:    sda_oe <= !cmd_read && !shreg[7];
              2'd1:    scl_oe <= 1'b0;
              2'd2:    shreg  <= {shreg[6:0], cmd_read && sda_s};
              default: scl_oe <= 1'b1;
            endcase
            ST_ACK: case (quarter)
              2'd0:    sda_oe <= cmd_read && !cmd_nack;
              2'd1:    scl_oe <= 1'b0;
              2'd2:    if (!cmd_read) slave_nack <= sda_s;
              default: scl_oe <= 1'b1;
            endcase
            ST_STOP: case (quarter)
              2'd0:    sda_oe <= 1'b1;
              2'd1:    scl_oe <= 1'b0;
              2'd2:    sda_oe <= 1'b0;
              default: ;
            endcase
            default: ;
          endcase
        end

        if (state_end) begin
          case (state)
            ST_START: begin
              if (cmd_byte)      state <= ST_BIT;
              else if (cmd_stop) state <= ST_STOP;
              else begin
                state <= ST_IDLE;
                busy  <= 1'b0;
              end
            end
            ST_BIT: begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) state <= ST_ACK;
            end
            ST_ACK: begin
              if (cmd_read) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
              end
              if (cmd_stop) state <= ST_STOP;
              else begin
                state <= ST_IDLE;
                busy  <= 1'b0;
              end
            end
            default: begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  // NOTE: every output of this always_comb gets a default first, so no path
  // through the case can leave rdata unassigned and infer a latch.
  always_comb begin
    rdata = '0;
    if (hit) begin
      case (reg_sel)
        REG_RXDATA: rdata[7:0] = rx_data;
        REG_STATUS: begin
          rdata[STAT_BUSY]     = busy;
          rdata[STAT_NACK]     = slave_nack;
          rdata[STAT_ERR]      = err;
          rdata[STAT_RX_VALID] = rx_valid;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
// Self-checking bench for i2c_master: open-drain bus with a behavioural slave,
// bit-level bus monitor and register/latency expectations computed from byte values.
module tb_i2c_master;

  localparam int          DIV   = 4;
  localparam logic [15:0] BASE  = 16'hF0;
  localparam int          LIMIT = 4000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] addr = BASE;
  logic [15:0] wdata = '0;
  logic        we = 1'b0;
  logic [15:0] rdata;
  logic        hit, scl_oe, sda_oe;
  logic        slave_sda_low = 1'b0;
  logic        slave_scl_low = 1'b0;
  wire         scl = !scl_oe && !slave_scl_low;
  wire         sda = !sda_oe && !slave_sda_low;

  int          tests_run = 0;
  int          tests_failed = 0;
  int          rises = 0;
  int          starts = 0;
  int          stops = 0;
  logic [8:0]  plan = 9'h1FF;
  logic        obs_q[$];
  logic        stretch_arm = 1'b0;

  i2c_master #(.DATA_W(16), .ADDR_W(16), .BASE_ADDR(BASE), .DIV(DIV)) dut (
    .clk    (clk),
    .rst    (rst),
    .addr   (addr),
    .wdata  (wdata),
    .we     (we),
    .rdata  (rdata),
    .hit    (hit),
    .scl_oe (scl_oe),
    .sda_oe (sda_oe),
    .scl_i  (scl),
    .sda_i  (sda)
  );

  always #5 clk = ~clk;

  // Bus monitor: SDA level at every SCL rise, plus START/STOP conditions.
  always @(posedge scl) begin
    obs_q.push_back(sda);
    rises++;
  end
  always @(negedge sda) if (scl) starts++;
  always @(posedge sda) if (scl) stops++;

  // Slave: plan holds the level it leaves on SDA for bits 0..8 of the frame.
  always @(negedge scl) slave_sda_low = (rises < 9) ? !plan[8 - rises] : 1'b0;

`ifdef I2C_CLOCK_STRETCH_EN
  always @(negedge scl) begin
    if (stretch_arm && rises == 3) begin
      stretch_arm   = 1'b0;
      slave_scl_low = 1'b1;
      @(negedge scl_oe);
      repeat (50) @(posedge clk);
      slave_scl_low = 1'b0;
    end
  end
`endif

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic check_lat(input string tag, input int cyc, input int expected);
`ifdef I2C_CLOCK_STRETCH_EN
    check(tag, 32'(cyc >= expected), 32'd1);
`else
    check(tag, 32'(cyc), 32'(expected));
`endif
  endtask

  function automatic int lat(input int s, input int b, input int p);
    return 4 * DIV * (s + 9 * b + p);
  endfunction

  function automatic logic [31:0] obs_word();
    logic [31:0] w = '0;
    foreach (obs_q[i]) w = {w[30:0], obs_q[i]};
    return w;
  endfunction

  task automatic arm(input logic [8:0] p);
    obs_q.delete();
    rises  = 0;
    starts = 0;
    stops  = 0;
    plan   = p;
    slave_sda_low = !p[8];
  endtask

  task automatic issue(input logic [15:0] cmd, input logic [1:0] off);
    @(negedge clk);
    addr  = BASE + 16'(off);
    wdata = cmd;
    we    = 1'b1;
    @(negedge clk);
    we    = 1'b0;
    addr  = BASE + 16'd2;
  endtask

  task automatic wait_idle(input string tag, output int cyc);
    cyc = 0;
    while (cyc < LIMIT) begin
      #1;
      if (!rdata[0]) break;
      cyc++;
      @(negedge clk);
    end
    check({tag, "_done"}, {31'd0, rdata[0]}, 32'd0);
  endtask

  task automatic rd(input logic [1:0] off, output logic [15:0] d);
    addr = BASE + 16'(off);
    #1;
    d = rdata;
    addr = BASE + 16'd2;
  endtask

  initial begin
    logic [15:0] d;
    int          cyc;
    logic [7:0]  tx, rx;
    logic        ack, nack;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_scl_oe", {31'd0, scl_oe}, 32'd0);
    check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    rd(2'd2, d); check("rst_status", {16'd0, d}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rd(2'd1, d); check("rst_rxdata", {16'd0, d}, 32'd0);

    // Address window decode
    addr = BASE + 16'd4; #1;
    check("hit_above", {31'd0, hit}, 32'd0);
    addr = BASE - 16'd1; #1;
    check("hit_below", {31'd0, hit}, 32'd0);
    addr = BASE + 16'd3; #1;
    check("hit_top", {31'd0, hit}, 32'd1);

    // Address write 0x3A with slave ACK
    arm(9'h1FE);
    issue(16'h0B3A, 2'd0);
    wait_idle("wr3a", cyc);
    check_lat("wr3a_lat", cyc, 176);
    check("wr3a_bits", obs_word(), {22'd0, 8'h3A, 1'b0, 1'b0});
    check("wr3a_nbits", 32'(obs_q.size()), 32'd10);
    check("wr3a_start_stop", 32'(starts * 16 + stops), 32'h11);
    rd(2'd2, d); check("wr3a_status", {16'd0, d}, 32'd0);
    check("wr3a_released", {30'd0, scl_oe, sda_oe}, 32'd0);

    // Same command, slave leaves SDA high at ACK
    arm(9'h1FF);
    issue(16'h0B3A, 2'd0);
    wait_idle("nack", cyc);
    rd(2'd2, d); check("nack_status", {16'd0, d}, 32'h2);

    // Write without STOP holds the bus
    arm(9'h1FE);
    issue(16'h03A1, 2'd0);
    wait_idle("hold", cyc);
    check_lat("hold_lat", cyc, lat(1, 1, 0));
    check("hold_scl", {31'd0, scl_oe}, 32'd1);
    rd(2'd2, d); check("hold_status", {16'd0, d}, 32'd0);

    // Read 0xE5 with master NACK and STOP
    arm({8'hE5, 1'b1});
    issue(16'h1C00, 2'd0);
    wait_idle("rd", cyc);
    check_lat("rd_lat", cyc, lat(0, 1, 1));
    check("rd_bits", obs_word(), {22'd0, 8'hE5, 1'b1, 1'b0});
    rd(2'd1, d); check("rd_rxdata", {16'd0, d}, 32'h00E5);
    rd(2'd2, d); check("rd_status", {16'd0, d}, 32'h8);

    // CMD store while busy is ignored and flags err
    arm(9'h1FE);
    issue(16'h0B55, 2'd0);
    repeat (20) @(negedge clk);
    issue(16'h0B11, 2'd0);
    rd(2'd2, d); check("busy_rej_status", {16'd0, d}, 32'hD);
    wait_idle("busy_rej", cyc);
    check("busy_rej_bits", obs_word(), {22'd0, 8'h55, 1'b0, 1'b0});
    rd(2'd2, d); check("busy_rej_after", {16'd0, d}, 32'hC);
    issue(16'h0000, 2'd3);
    rd(2'd2, d); check("clear_status", {16'd0, d}, 32'h0);

    // WRITE+READ together and an empty command
    issue(16'h0600, 2'd0);
    wait_idle("conflict", cyc);
    check("conflict_lat", 32'(cyc), 32'd0);
    rd(2'd2, d); check("conflict_status", {16'd0, d}, 32'h4);
    issue(16'h0000, 2'd3);
    issue(16'h10FF, 2'd0);
    wait_idle("noop", cyc);
    check("noop_lat", 32'(cyc), 32'd0);
    rd(2'd2, d); check("noop_status", {16'd0, d}, 32'h0);

    // Randomised write (held) + read (STOP) pairs
    for (int it = 0; it < 3; it++) begin
      tx   = 8'($urandom);
      rx   = 8'($urandom);
      ack  = 1'($urandom);
      nack = 1'($urandom);
      arm({8'hFF, !ack});
      issue({8'h03, tx}, 2'd0);
      wait_idle("rnd_wr", cyc);
      check("rnd_wr_bits", obs_word(), {23'd0, tx, !ack});
      rd(2'd2, d); check("rnd_wr_status", {16'd0, d}, {30'd0, !ack, 1'b0});
      arm({rx, 1'b1});
      issue({3'b000, nack, 4'hC, 8'h00}, 2'd0);
      wait_idle("rnd_rd", cyc);
      check_lat("rnd_rd_lat", cyc, lat(0, 1, 1));
      check("rnd_rd_bits", obs_word(), {22'd0, rx, nack, 1'b0});
      rd(2'd1, d); check("rnd_rd_rxdata", {16'd0, d}, {24'd0, rx});
      rd(2'd2, d); check("rnd_rd_status", {16'd0, d}, {28'd0, 1'b1, 1'b0, !ack, 1'b0});
      issue(16'h0000, 2'd3);
    end

`ifdef I2C_CLOCK_STRETCH_EN
    // Slave stretches SCL during bit 3 of a read
    arm(9'h1FE);
    issue(16'h0342, 2'd0);
    wait_idle("st_wr", cyc);
    arm({8'h9C, 1'b1});
    stretch_arm = 1'b1;
    issue(16'h1C00, 2'd0);
    wait_idle("st_rd", cyc);
    check("st_lat", 32'(cyc >= lat(0, 1, 1) + 50), 32'd1);
    rd(2'd1, d); check("st_rxdata", {16'd0, d}, 32'h009C);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/i2c_master.md
# i2c_master

Memory-mapped, parametrised I2C master peripheral that replaces CPU bit-banging of SCL/SDA. It sits on the CPU data-memory port beside data RAM. The CPU issues one command word per byte-level transaction: optional START, one byte write or read with ACK, optional STOP. The block then sequences the open-drain bus on its own and reports status through polled registers.

## Interface
Parameters:
- `DATA_W`, 16: CPU register/bus width; must be ≥ 13.
- `ADDR_W`, 16: CPU address width.
- `BASE_ADDR`, 16'hF0: word address of register 0; the block decodes `BASE_ADDR`..`BASE_ADDR+3`.
- `DIV`, 16: clk cycles per quarter SCL period; must be ≥ 2. SCL period = 4·DIV.

Ports:
- `clk` in 1: single clock; all state is on its rising edge.
- `rst` in 1: asynchronous active-low reset.
- `addr` in ADDR_W: CPU data address.
- `wdata` in DATA_W: store data.
- `we` in 1: store strobe, one cycle per store.
- `rdata` out DATA_W: load data, combinational from `addr`; 0 outside the window.
- `hit` out 1: `addr` is inside the 4-word window, combinational.
- `scl_oe` out 1: 1 = drive SCL low, 0 = release.
- `sda_oe` out 1: 1 = drive SDA low, 0 = release.
- `scl_i` in 1: SCL pad level.
- `sda_i` in 1: SDA pad level.

## Operation
Register map (word offsets):
- 0 CMD (W):
  - [7:0] tx byte
  - [8] START
  - [9] WRITE
  - [10] READ
  - [11] STOP
  - [12] master NACK on read (1 = NACK)
- 1 RXDATA (R): [7:0] last byte read.
- 2 STATUS (R):
  - [0] busy
  - [1] slave NACK from the last write
  - [2] err (sticky)
  - [3] rx_valid
- 3 CLEAR (W): any store clears err and rx_valid.

Command rules:
- CMD store while busy is ignored and sets err.
- CMD with WRITE and READ both set: set err, execute nothing.
- CMD with no bits in [11:8]: no-op, busy stays 0.
- Execution order inside one command: START → byte → STOP.

FSM states: IDLE, START, BIT, ACK, STOP.
- IDLE → START if START is set.
- IDLE → BIT if WRITE or READ is set.
- IDLE → STOP if STOP is set.
- START → BIT if WRITE or READ is set, otherwise → STOP if STOP is set, otherwise → IDLE.
- BIT runs 8 bits, MSB first, then → ACK.
- ACK → STOP if STOP is set, otherwise → IDLE.
- STOP → IDLE.

Each state lasts 4 quarter phases q0–q3, each DIV cycles long:
- BIT / ACK:
  - q0: set sda_oe (write: ~bit; read, or write-ACK: 0; read-ACK: NACK bit ? 0 : 1).
  - q1: release SCL.
  - q2: sample synchronised sda_i (read data, or slave ACK).
  - q3: assert scl_oe.
- START:
  - q0: release SDA.
  - q1: release SCL.
  - q2: assert sda_oe.
  - q3: assert scl_oe.
  - This sequence also serves as a repeated START.
- STOP:
  - q0: assert sda_oe.
  - q1: release SCL.
  - q2: release SDA.
  - q3: hold.

Status updates:
- Slave NACK bit is updated at ACK q2 of a write.
- RXDATA is loaded and rx_valid set at the end of ACK on a read.
- After a command without STOP, SCL stays driven low; the bus is held for the next command.

## Timing
- `scl_i` and `sda_i` pass through 2-flop synchronisers; values are sampled 2 cycles late.
- Reset values: `scl_oe`=0, `sda_oe`=0, busy=0, all status bits 0, RXDATA=0, FSM=IDLE, phase counters 0.
- Command acceptance:
  - busy rises the cycle after an accepted CMD store.
  - q0 of the first state starts that same cycle.
- busy falls the cycle after the last q3 ends.
- Total latency = 4·DIV·(S + 9·B + P) cycles, where S, B, P ∈ {0,1} flag START, byte, STOP.
- CMD store and CLEAR store in the same cycle cannot occur (single address); CLEAR during busy is allowed.
- Reset mid-transaction:
  - Both lines are released immediately.
  - The slave may see an aborted byte; software must issue START+STOP afterwards.

## Configuration
- `I2C_CLOCK_STRETCH_EN` defined:
  - At q1 the quarter counter freezes after releasing SCL until synchronised `scl_i`=1.
  - q2 starts DIV cycles after SCL is seen high.
- Undefined: `scl_i` is ignored; timing is exactly 4·DIV per bit.

## Structure
- `i2c_pkg`:
  - state enum
  - CMD bit-position constants
  - register offset constants (CMD=0, RXDATA=1, STATUS=2, CLEAR=3)
  - STATUS bit positions
- Sub-module `i2c_phase_gen`:
  - DIV counter and 2-bit quarter counter
  - q-strobe output and end-of-state pulse
  - stretch freeze input

## Test plan
- Reset: assert rst with DIV=4 → scl_oe=0, sda_oe=0, STATUS=0.
- Address write: CMD=0x0B3A (START+WRITE+STOP, 0x3A), model slave ACKs → SDA bits 0,0,1,1,1,0,1,0 on SCL rises; busy high for 4·4·11=176 cycles; STATUS[1]=0.
- Slave NACK: same command with SDA left high at ACK → STATUS[1]=1 after completion.
- Read: after held bus, CMD=0x1C00 (READ+STOP+NACK) with slave sending 0xE5 → RXDATA=0x00E5, rx_valid=1, SDA released during the ACK bit.
- Command rejection:
  - CMD store during busy → ignored, err=1.
  - Store to CLEAR → err=0, rx_valid=0.
- Stretch (macro on): slave holds SCL low 50 cycles after q1 → q2 sampling is delayed by 50 cycles plus sync delay; data is still correct.
